// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags feeding the rename map table.
//   clock            system clock
//   reset            asynchronous active-low reset; restores the identity-mapped full list
//   en               global stall; when low all state holds
//   dispatch_en      consume NUM_SUPER tags this cycle (ignored while free_hazard)
//   ROB_idx          ROB slot of each dispatching lane; receives a head snapshot
//   retire_en        per-lane retire valid
//   retire_Told_idx  tags returned to the tail
//   rollback_en      restore head from the snapshot at ROB_rollback_idx
//   ROB_rollback_idx ROB slot of the mispredicted branch
//   FL_T_idx         next free tags; lane i is the entry at head+i
//   free_hazard      fewer than NUM_SUPER tags available
//   free_count       number of free tags (0..DEPTH)
module free_list #(
    parameter int NUM_PR    = 64,
    parameter int NUM_ARCH  = 32,
    parameter int NUM_SUPER = 2,
    parameter int NUM_ROB   = 32,
    parameter int DEPTH     = NUM_PR - NUM_ARCH,
    localparam int TW = $clog2(NUM_PR),
    localparam int RW = $clog2(NUM_ROB),
    localparam int IW = $clog2(DEPTH),
    localparam int PW = IW + 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          dispatch_en,
    input  logic [NUM_SUPER-1:0][RW-1:0]  ROB_idx,
    input  logic [NUM_SUPER-1:0]          retire_en,
    input  logic [NUM_SUPER-1:0][TW-1:0]  retire_Told_idx,
    input  logic                          rollback_en,
    input  logic [RW-1:0]                 ROB_rollback_idx,
    output logic [NUM_SUPER-1:0][TW-1:0]  FL_T_idx,
    output logic                          free_hazard,
    output logic [CW-1:0]                 free_count
);

    logic [TW-1:0] fifo [DEPTH];
    logic [PW-1:0] snap_head [NUM_ROB];
    logic [PW-1:0] head, tail, tail_nxt;
    logic [PW-1:0] rd_ptr [NUM_SUPER];
    logic [PW-1:0] wr_ptr [NUM_SUPER];
    logic          do_dispatch;

    // Pointers carry a wrap bit in the MSB; advancing past DEPTH-1 folds the index and flips it.
    function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input int n);
        int s;
        s = int'(p[IW-1:0]) + n;
        return (s >= DEPTH) ? {~p[IW], IW'(s - DEPTH)} : {p[IW], IW'(s)};
    endfunction

    always_comb begin
        int diff;
        diff = int'(tail[IW-1:0]) - int'(head[IW-1:0]) + ((tail[IW] != head[IW]) ? DEPTH : 0);
        free_count = CW'(diff);
        free_hazard = free_count < CW'(NUM_SUPER);
        for (int i = 0; i < NUM_SUPER; i++) begin
            rd_ptr[i] = adv(head, i);
            FL_T_idx[i] = fifo[rd_ptr[i][IW-1:0]];
        end
    end

    // Retiring lanes are packed onto consecutive tail slots, skipping disabled lanes.
    always_comb begin
        int c;
        c = 0;
        for (int k = 0; k < NUM_SUPER; k++) begin
            wr_ptr[k] = adv(tail, c);
            c = c + (retire_en[k] ? 1 : 0);
        end
        tail_nxt = adv(tail, c);
    end

    assign do_dispatch = dispatch_en && !rollback_en && !free_hazard;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                fifo[i] <= TW'(NUM_ARCH + i);
            for (int i = 0; i < NUM_ROB; i++)
                snap_head[i] <= '0;
            head <= '0;
            tail <= {1'b1, {IW{1'b0}}};
        end else if (en) begin
            for (int k = 0; k < NUM_SUPER; k++)
                if (retire_en[k])
                    fifo[wr_ptr[k][IW-1:0]] <= retire_Told_idx[k];
            tail <= tail_nxt;
            if (rollback_en)
                head <= snap_head[ROB_rollback_idx];
            else if (do_dispatch) begin
                head <= adv(head, NUM_SUPER);
                // Each lane records the head as it stands once its own tag is taken.
                for (int j = 0; j < NUM_SUPER; j++)
                    snap_head[ROB_idx[j]] <= adv(head, j + 1);
            end
        end
    end

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: scoreboard bench for free_list; stimulus queues expected outputs, a monitor checks them.
module tb_free_list;

    logic            clock;
    logic            reset;
    logic            en;
    logic            dispatch_en;
    logic [1:0][4:0] ROB_idx;
    logic [1:0]      retire_en;
    logic [1:0][5:0] retire_Told_idx;
    logic            rollback_en;
    logic [4:0]      ROB_rollback_idx;
    logic [1:0][5:0] FL_T_idx;
    logic            free_hazard;
    logic [5:0]      free_count;

    typedef struct {
        int         cyc;
        string      nm;
        logic [5:0] t0;
        logic [5:0] t1;
        logic [5:0] cnt;
        logic       haz;
    } exp_t;

    exp_t q[$];
    int   cyc_n = 0;
    int   checks = 0;
    int   errors = 0;

    free_list dut (
        .clock(clock),
        .reset(reset),
        .en(en),
        .dispatch_en(dispatch_en),
        .ROB_idx(ROB_idx),
        .retire_en(retire_en),
        .retire_Told_idx(retire_Told_idx),
        .rollback_en(rollback_en),
        .ROB_rollback_idx(ROB_rollback_idx),
        .FL_T_idx(FL_T_idx),
        .free_hazard(free_hazard),
        .free_count(free_count)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc_n <= cyc_n + 1;

    always @(negedge clock) begin
        if (free_count > 6'd32) begin
            errors++;
            $display("FAIL bound: free_count=%0d exceeds 32", free_count);
        end
        while (q.size() > 0 && q[0].cyc <= cyc_n) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc_n || FL_T_idx[0] !== e.t0 || FL_T_idx[1] !== e.t1 ||
                free_count !== e.cnt || free_hazard !== e.haz) begin
                errors++;
                $display("FAIL %s cyc %0d: got T={%0d,%0d} cnt=%0d haz=%0d, want T={%0d,%0d} cnt=%0d haz=%0d",
                         e.nm, cyc_n, FL_T_idx[0], FL_T_idx[1], free_count, free_hazard,
                         e.t0, e.t1, e.cnt, e.haz);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [5:0] tg(int n);
        return 6'((10 + n) % 64);
    endfunction

    function automatic logic [5:0] ord(int k);
        return (k == 0) ? 6'd5 : (k == 1) ? 6'd7 : (k == 2) ? 6'd9 : tg(k - 3);
    endfunction

    // Fifo contents during the drain phase: slots 0/1 were refilled with 2/3, the rest are reset values.
    function automatic logic [5:0] fl_val(int i);
        return (i == 0) ? 6'd2 : (i == 1) ? 6'd3 : 6'(32 + i);
    endfunction

    task automatic step(input string nm, input logic de, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [1:0] re, input logic [5:0] d0, input logic [5:0] d1,
                        input logic rb, input logic [4:0] ri,
                        input logic [5:0] e0, input logic [5:0] e1, input logic [5:0] ec, input logic eh);
        dispatch_en = de;
        ROB_idx[0] = r0;
        ROB_idx[1] = r1;
        retire_en = re;
        retire_Told_idx[0] = d0;
        retire_Told_idx[1] = d1;
        rollback_en = rb;
        ROB_rollback_idx = ri;
        q.push_back('{cyc_n + 1, nm, e0, e1, ec, eh});
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset = 0;
        en = 1;
        dispatch_en = 0;
        ROB_idx = '0;
        retire_en = '0;
        retire_Told_idx = '0;
        rollback_en = 0;
        ROB_rollback_idx = '0;
        q.push_back('{1, "reset", 6'd32, 6'd33, 6'd32, 1'b0});
        @(posedge clock);
        @(negedge clock);
        reset = 1;
        step("disp0", 1, 0, 1, 2'b00, 0, 0, 0, 0, 34, 35, 30, 0);
        step("disp1", 1, 2, 3, 2'b00, 0, 0, 0, 0, 36, 37, 28, 0);
        step("disp2", 1, 4, 5, 2'b00, 0, 0, 0, 0, 38, 39, 26, 0);
        step("rb_idx1", 1, 9, 10, 2'b00, 0, 0, 1, 1, 34, 35, 30, 0);
        step("rb_idx0", 0, 0, 0, 2'b00, 0, 0, 1, 0, 33, 34, 31, 0);
        step("rb_idx5", 0, 0, 0, 2'b00, 0, 0, 1, 5, 38, 39, 26, 0);
        en = 0;
        step("stall", 1, 11, 12, 2'b11, 60, 61, 1, 0, 38, 39, 26, 0);
        en = 1;
        step("rb_retire", 0, 0, 0, 2'b11, 2, 3, 1, 3, 36, 37, 30, 0);
        for (int s = 1; s <= 15; s++) begin
            int h;
            h = 4 + 2 * s;
            step("drain", 1, 5'(2 * s), 5'(2 * s + 1), 2'b00, 0, 0, 0, 0,
                 fl_val(h % 32), fl_val((h + 1) % 32), 6'(30 - 2 * s), (30 - 2 * s) < 2);
        end
        step("hazard_hold", 1, 20, 21, 2'b00, 0, 0, 0, 0, 34, 35, 0, 1);
        step("retire_10", 0, 0, 0, 2'b10, 60, 5, 0, 0, 5, 35, 1, 1);
        step("retire_11", 0, 0, 0, 2'b11, 7, 9, 0, 0, 5, 7, 3, 0);
        for (int c = 0; c < 40; c++)
            step("wrap", 1, 5'(2 * c), 5'(2 * c + 1), 2'b11, tg(2 * c), tg(2 * c + 1), 0, 0,
                 ord(2 * c + 2), ord(2 * c + 3), 3, 0);
        en = 0;
        #1 reset = 0;
        q.push_back('{cyc_n + 1, "mid_reset", 6'd32, 6'd33, 6'd32, 1'b0});
        @(posedge clock);
        @(negedge clock);
        reset = 1;
        en = 1;
        step("rb_after_rst", 0, 0, 0, 2'b00, 0, 0, 1, 5, 32, 33, 32, 0);
        rollback_en = 0;
        repeat (2) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
